// File: rtl/csr_access_unit_pkg.sv
// csr_access_unit_pkg: Zicsr funct3 codes, FSM states and CSR address constants.
package csr_access_unit_pkg;

    localparam int CSR_AW_DEF = 12;
    localparam int XLEN_DEF   = 32;

    // CSRs whose address bits [11:10] equal this prefix are read-only.
    localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

    typedef enum logic [2:0] {
        CSR_RW  = 3'b001,
        CSR_RS  = 3'b010,
        CSR_RC  = 3'b011,
        CSR_RWI = 3'b101,
        CSR_RSI = 3'b110,
        CSR_RCI = 3'b111
    } csr_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CAPT  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } csr_state_e;

endpackage

// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences one Zicsr instruction onto the CSR file ports
// (registered read, read-modify-write, single-cycle write) and returns the old value.
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter int CSR_AW = CSR_AW_DEF,
    parameter int XLEN   = XLEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        op_i,
    input  logic [CSR_AW-1:0] csr_addr_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [4:0]        zimm_i,
    input  logic              rd_zero_i,
    input  logic              rs1_zero_i,
    input  logic              flush_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [XLEN-1:0]   resp_rdata_o,
    output logic              resp_illegal_o,
    output logic [CSR_AW-1:0] csr_raddr_o,
    input  logic [XLEN-1:0]   csr_rdata_i,
    output logic              csr_we_o,
    output logic [CSR_AW-1:0] csr_waddr_o,
    output logic [XLEN-1:0]   csr_wdata_o
);

    csr_state_e        state_q, state_d;
    logic [1:0]        kind_q, kind_d;
    logic [CSR_AW-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   src_q, src_d;
    logic [XLEN-1:0]   old_q, old_d;
    logic              wr_q, wr_d;
    logic              ill_q, ill_d;

    logic            accept, is_rw, do_read, do_write, illegal;
    logic [XLEN-1:0] wdata;

    assign accept   = req_valid_i & req_ready_o & ~flush_i;
    assign is_rw    = (op_i == CSR_RW) | (op_i == CSR_RWI);
    assign do_read  = ~(is_rw & rd_zero_i);
    assign do_write = is_rw | ~rs1_zero_i;
    assign illegal  = (op_i[1:0] == 2'b00) |
                      (do_write & (csr_addr_i[CSR_AW-1 -: 2] == CSR_RO_PREFIX));

    // kind_q holds funct3[1:0]: 01 write, 10 set, 11 clear; old_q is 0 when no read ran.
    assign wdata = (kind_q == 2'b01) ? src_q :
                   (kind_q == 2'b10) ? (old_q | src_q) : (old_q & ~src_q);

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        addr_d  = addr_q;
        src_d   = src_q;
        old_d   = old_q;
        wr_d    = wr_q;
        ill_d   = ill_q;
        case (state_q)
            S_IDLE: if (accept) begin
                kind_d  = op_i[1:0];
                addr_d  = csr_addr_i;
                src_d   = op_i[2] ? {{(XLEN-5){1'b0}}, zimm_i} : rs1_data_i;
                old_d   = '0;
                wr_d    = do_write;
                ill_d   = illegal;
                state_d = illegal ? S_RESP : (do_read ? S_READ : S_WRITE);
            end
            S_READ:  state_d = S_CAPT;
            S_CAPT: begin
                old_d   = csr_rdata_i;
                state_d = wr_q ? S_WRITE : S_RESP;
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = resp_ready_i ? S_IDLE : S_RESP;
            default: state_d = S_IDLE;
        endcase
        if (flush_i && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            kind_q  <= '0;
            addr_q  <= '0;
            src_q   <= '0;
            old_q   <= '0;
            wr_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            addr_q  <= addr_d;
            src_q   <= src_d;
            old_q   <= old_d;
            wr_q    <= wr_d;
            ill_q   <= ill_d;
        end
    end

    assign req_ready_o    = state_q == S_IDLE;
    assign resp_valid_o   = state_q == S_RESP;
    assign resp_rdata_o   = resp_valid_o ? old_q : '0;
    assign resp_illegal_o = resp_valid_o & ill_q;
    assign csr_raddr_o    = (state_q == S_READ) ? addr_q : '0;
    assign csr_we_o       = (state_q == S_WRITE) & ~flush_i;
    assign csr_waddr_o    = (state_q == S_WRITE) ? addr_q : '0;
    assign csr_wdata_o    = (state_q == S_WRITE) ? wdata : '0;

endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: directed vector table plus hand sequences for stall, flush and reset,
// against a behavioural CSR file with a one-cycle registered read.
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, rd_zero, rs1_zero, flush;
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] rs1;
    logic [4:0]  zimm;
    logic        resp_valid, resp_ready, resp_illegal;
    logic [31:0] resp_rdata;
    logic [11:0] csr_raddr, csr_waddr;
    logic [31:0] csr_rdata, csr_wdata;
    logic        csr_we;

    logic        pre_en;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;
    logic [31:0] mem [0:4095];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    csr_access_unit dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .op_i(op), .csr_addr_i(addr), .rs1_data_i(rs1), .zimm_i(zimm),
        .rd_zero_i(rd_zero), .rs1_zero_i(rs1_zero), .flush_i(flush),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_illegal_o(resp_illegal),
        .csr_raddr_o(csr_raddr), .csr_rdata_i(csr_rdata),
        .csr_we_o(csr_we), .csr_waddr_o(csr_waddr), .csr_wdata_o(csr_wdata)
    );

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (csr_we) mem[csr_waddr] <= csr_wdata;
        csr_rdata <= mem[csr_raddr];
    end

    typedef struct {
        logic [2:0]  op;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  zimm;
        logic        rd_zero;
        logic        rs1_zero;
        logic [31:0] init;
        int          lat;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        ill;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        req_valid = 1'b1; op = v.op; addr = v.addr; rs1 = v.rs1; zimm = v.zimm;
        rd_zero = v.rd_zero; rs1_zero = v.rs1_zero;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat = 0, wcnt = 0;
        logic [31:0] wd = '0;
        logic [11:0] wa = '0, ra1 = '0;
        preload(v.addr, v.init);
        @(negedge clk);
        drive(v);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) ra1 = csr_raddr;
            if (csr_we) begin wcnt++; wd = csr_wdata; wa = csr_waddr; end
            if (resp_valid) lat = c;
        end
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d raddr", idx), {20'b0, ra1}, (v.lat >= 3) ? {20'b0, v.addr} : 32'b0);
        chk($sformatf("v%0d we_count", idx), wcnt, {31'b0, v.we});
        if (v.we) begin
            chk($sformatf("v%0d wdata", idx), wd, v.wdata);
            chk($sformatf("v%0d waddr", idx), {20'b0, wa}, {20'b0, v.addr});
        end
        chk($sformatf("v%0d rdata", idx), resp_rdata, v.rdata);
        chk($sformatf("v%0d illegal", idx), {31'b0, resp_illegal}, {31'b0, v.ill});
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk($sformatf("v%0d ready_after", idx), {31'b0, req_ready}, 32'd1);
        chk($sformatf("v%0d mem", idx), mem[v.addr], v.we ? v.wdata : v.init);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, " req_ready"}, {31'b0, req_ready}, 32'd1);
        chk({nm, " resp_valid"}, {31'b0, resp_valid}, 32'd0);
        chk({nm, " resp_rdata"}, resp_rdata, 32'd0);
        chk({nm, " resp_illegal"}, {31'b0, resp_illegal}, 32'd0);
        chk({nm, " we"}, {31'b0, csr_we}, 32'd0);
        chk({nm, " raddr"}, {20'b0, csr_raddr}, 32'd0);
        chk({nm, " waddr"}, {20'b0, csr_waddr}, 32'd0);
        chk({nm, " wdata"}, csr_wdata, 32'd0);
    endtask

    initial begin
        //            op      addr    rs1           zimm   rdz   r1z   init          lat we wdata         rdata         ill
        vecs[0]  = '{3'b010, 12'h340, 32'h0000_000F, 5'h1F, 1'b0, 1'b0, 32'h0000_00F0, 4, 1, 32'h0000_00FF, 32'h0000_00F0, 0};
        vecs[1]  = '{3'b111, 12'h340, 32'hFFFF_FFFF, 5'h0F, 1'b0, 1'b0, 32'h0000_00FF, 4, 1, 32'h0000_00F0, 32'h0000_00FF, 0};
        vecs[2]  = '{3'b010, 12'h340, 32'h0000_0000, 5'h1F, 1'b0, 1'b1, 32'h0000_00F0, 3, 0, 32'h0,         32'h0000_00F0, 0};
        vecs[3]  = '{3'b001, 12'h305, 32'h8000_0000, 5'h1F, 1'b1, 1'b0, 32'h0000_1234, 2, 1, 32'h8000_0000, 32'h0,         0};
        vecs[4]  = '{3'b001, 12'hF14, 32'h0000_0005, 5'h1F, 1'b0, 1'b0, 32'h0000_0000, 1, 0, 32'h0,         32'h0,         1};
        vecs[5]  = '{3'b100, 12'h340, 32'h0000_000F, 5'h00, 1'b0, 1'b0, 32'h0000_00F0, 1, 0, 32'h0,         32'h0,         1};
        vecs[6]  = '{3'b001, 12'h341, 32'h1234_5678, 5'h1F, 1'b0, 1'b0, 32'hAAAA_5555, 4, 1, 32'h1234_5678, 32'hAAAA_5555, 0};
        vecs[7]  = '{3'b110, 12'h300, 32'hFFFF_FFFF, 5'h11, 1'b0, 1'b0, 32'h0000_0008, 4, 1, 32'h0000_0019, 32'h0000_0008, 0};
        vecs[8]  = '{3'b011, 12'h342, 32'h0F0F_0000, 5'h1F, 1'b0, 1'b0, 32'hFFFF_FFFF, 4, 1, 32'hF0F0_FFFF, 32'hFFFF_FFFF, 0};
        vecs[9]  = '{3'b010, 12'hF14, 32'h0000_0000, 5'h1F, 1'b0, 1'b1, 32'h0000_DEAD, 3, 0, 32'h0,         32'h0000_DEAD, 0};
        vecs[10] = '{3'b101, 12'h340, 32'hFFFF_FFFF, 5'h1F, 1'b1, 1'b0, 32'h0000_00F0, 2, 1, 32'h0000_001F, 32'h0,         0};
        vecs[11] = '{3'b111, 12'hC00, 32'hFFFF_FFFF, 5'h00, 1'b0, 1'b1, 32'h0000_0077, 3, 0, 32'h0,         32'h0000_0077, 0};
        vecs[12] = '{3'b000, 12'h340, 32'h0000_0000, 5'h00, 1'b0, 1'b0, 32'h0000_00F0, 1, 0, 32'h0,         32'h0,         1};
        vecs[13] = '{3'b010, 12'h343, 32'h0000_0003, 5'h1F, 1'b1, 1'b0, 32'h0000_0004, 4, 1, 32'h0000_0007, 32'h0000_0004, 0};
        vecs[14] = '{3'b101, 12'hC01, 32'hFFFF_FFFF, 5'h03, 1'b1, 1'b0, 32'h0000_0009, 1, 0, 32'h0,         32'h0,         1};

        rst = 1'b0; req_valid = 1'b0; op = '0; addr = '0; rs1 = '0; zimm = '0;
        rd_zero = 1'b0; rs1_zero = 1'b0; flush = 1'b0; resp_ready = 1'b0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        #1;
        chk_idle_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

        // Response stall, then a request held across the handshake cycle.
        preload(12'h340, 32'h0000_00F0);
        preload(12'h343, 32'h0000_0055);
        @(negedge clk);
        drive(vecs[0]);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        for (int h = 0; h < 5; h++) begin
            chk($sformatf("stall%0d valid", h), {31'b0, resp_valid}, 32'd1);
            chk($sformatf("stall%0d rdata", h), resp_rdata, 32'h0000_00F0);
            chk($sformatf("stall%0d req_ready", h), {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        req_valid = 1'b1; op = 3'b010; addr = 12'h343; rs1 = '0; zimm = 5'h1F;
        rd_zero = 1'b0; rs1_zero = 1'b1;
        chk("hs req_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("post_hs valid", {31'b0, resp_valid}, 32'd0);
        chk("post_hs req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b accepted", {31'b0, req_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("b2b valid", {31'b0, resp_valid}, 32'd1);
        chk("b2b rdata", resp_rdata, 32'h0000_0055);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;

        // Flush during WRITE: no write pulse, no response.
        preload(12'h340, 32'h0000_00F0);
        @(negedge clk);
        drive(vecs[0]);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_w we", {31'b0, csr_we}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_w req_ready", {31'b0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("flush_w no_resp", {31'b0, resp_valid}, 32'd0);
        chk("flush_w mem", mem[12'h340], 32'h0000_00F0);

        // Flush in IDLE blocks a same-cycle request.
        @(negedge clk);
        req_valid = 1'b1; op = 3'b001; addr = 12'h340; rs1 = 32'h1111_1111; zimm = 5'h0;
        rd_zero = 1'b1; rs1_zero = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_i req_ready", {31'b0, req_ready}, 32'd1);
        repeat (4) @(negedge clk);
        chk("flush_i no_resp", {31'b0, resp_valid}, 32'd0);
        chk("flush_i mem", mem[12'h340], 32'h0000_00F0);

        // Asynchronous reset while in CAPT.
        @(negedge clk);
        drive(vecs[0]);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk_idle_outputs("rst_capt");
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_capt no_resp", {31'b0, resp_valid}, 32'd0);
        chk("rst_capt mem", mem[12'h340], 32'h0000_00F0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
Initiator side of the CSR register-file port. Accepts one decoded Zicsr instruction at a time from the execute stage and sequences it onto the CSR file's write port (we/waddr/wdata) and registered read port (raddr -> rdata one cycle later). It performs read-modify-write for CSRRW/RS/RC and the immediate forms, then returns the old CSR value for rd through a valid/ready response.

Parameters:
CSR_AW, 12, CSR address width
XLEN, 32, data width (matches RegBus)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low (RstEnable = 0)
req_valid_i  in  1  CSR instruction request valid
req_ready_o  out  1  unit can accept a request (IDLE only)
op_i  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
csr_addr_i  in  CSR_AW  target CSR address
rs1_data_i  in  XLEN  rs1 operand (register forms)
zimm_i  in  5  zero-extended immediate (I forms)
rd_zero_i  in  1  rd == x0
rs1_zero_i  in  1  rs1 field == 0 (also zimm == 0 for I forms)
flush_i  in  1  pipeline flush; aborts the in-flight op
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response consumed
resp_rdata_o  out  XLEN  old CSR value (0 if no read performed)
resp_illegal_o  out  1  illegal-instruction flag
csr_raddr_o  out  CSR_AW  CSR read address
csr_rdata_i  in  XLEN  CSR read data, valid 1 cycle after raddr
csr_we_o  out  1  CSR write enable, single-cycle pulse
csr_waddr_o  out  CSR_AW  CSR write address
csr_wdata_o  out  XLEN  CSR write data

Behaviour:
- FSM states IDLE, READ, CAPT, WRITE, RESP; state register reset asynchronously to IDLE.
- Reset values: req_ready_o 1, resp_valid_o 0, resp_rdata_o 0, resp_illegal_o 0, csr_we_o 0, all address/data outputs 0.
- Accept on req_valid_i & req_ready_o (IDLE only); latch op, addr, source operand (rs1_data_i or zero-extended zimm_i), rd_zero_i, rs1_zero_i.
- do_read = !(op is RW/RWI && rd_zero). do_write = op is RW/RWI || !rs1_zero.
- Illegal: op 000 or 100, or do_write with addr[11:10] == 2'b11 (read-only). Illegal -> RESP directly with resp_illegal_o=1, rdata 0; no CSR read or write issued.
- IDLE -> READ if do_read, else WRITE.
- READ: csr_raddr_o = latched addr. -> CAPT.
- CAPT: capture csr_rdata_i into old-value register. -> WRITE if do_write, else RESP.
- WRITE: csr_we_o = 1 for exactly one cycle; csr_waddr_o = addr. wdata = src (RW), old|src (RS), old&~src (RC); for RW without read, old is unused. -> RESP.
- RESP: resp_valid_o held until resp_ready_i; resp_rdata_o/resp_illegal_o stable while valid. Handshake -> IDLE; next request accepted the following cycle.
- Latency accept-to-resp_valid: full RMW 4 cycles; read-only (RS/RC, rs1_zero) 3; RW with rd=x0 2; illegal 1.
- csr_we_o = (state==WRITE) & !flush_i (the only combinational gate).
- flush_i in READ/CAPT/WRITE/RESP: next state IDLE, no response, no write. In IDLE: ignored, and a same-cycle request is not accepted.
- Async reset mid-operation: outputs return to reset values immediately; in-flight op discarded.
- Arithmetic is bitwise only, XLEN bits, no carries.

Decomposition:
- bitty_defs.v gains CSR op funct3 codes (CSR_RW..CSR_RCI), FSM state encodings, CSR_AW, and the read-only address-prefix constant.
- Single module; no sub-module warranted. Bench uses a behavioural CSR model with 1-cycle registered read.

Test Plan:
- CSRRS mscratch(0x340)=0x0000_00F0, rs1=0x0F: raddr 0x340 at T+1, we pulse at T+3 with wdata 0x0000_00FF, resp_valid at T+4 with rdata 0x0000_00F0.
- CSRRCI 0x340 (=0xFF), zimm=0x0F: wdata 0x0000_00F0, rdata 0xFF; CSRRS rs1=x0: no we pulse, resp at T+3 with old value.
- CSRRW rd=x0 to mtvec(0x305), rs1=0x8000_0000: no read cycle, we at T+1 with 0x8000_0000, resp_valid T+2 with rdata 0.
- CSRRW to 0xF14 (mhartid) -> resp_illegal_o=1 at T+1, csr_we_o never asserted; op 100 -> illegal likewise.
- resp_ready_i held low 5 cycles: resp_valid/rdata stable, req_ready_o low; new req accepted the cycle after handshake.
- flush_i asserted in WRITE -> no we pulse, no resp, IDLE next cycle; rst low in CAPT -> all outputs 0 asynchronously, FSM IDLE.
